reg_file_8x8: RTL and testbench

Eight-entry, 8-bit register file for the single-cycle processor datapath, sitting between the instruction decoder and the ALU operand inputs. It is the write side and storage counterpart of the ALU's 8-to-1 operand selection: one synchronous write port decodes a 3-bit address into one of eight registers, and two independent combinational read ports select operands. Per-register valid bits and a write counter support bring-up and verification.

---
 rtl/reg_file_8x8.sv | 86 ++++++++
 tb/tb_reg_file_8x8.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_8x8.sv
// ============================================================================
// Module   : reg_file_8x8
// Summary  : 8 x 8-bit register file, one synchronous write port, two
//            combinational read ports, per-entry valid bits, write counter.
//            Optional write-to-read forwarding: define REG_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_8x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic [ADDR_WIDTH-1:0] inaddress,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] out1address,
  input  logic [ADDR_WIDTH-1:0] out2address,
  output logic [DATA_WIDTH-1:0] regout1,
  output logic [DATA_WIDTH-1:0] regout2,
  output logic                  out1valid,
  output logic                  out2valid,
  output logic [7:0]            wrcount
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic [c_DEPTH-1:0]    r_valid;
  logic [7:0]            r_wrcount;
  logic [c_DEPTH-1:0]    w_wr_sel;
  logic                  w_fwd1;
  logic                  w_fwd2;

  // Full one-hot write decode; every address maps to a register.
  always_comb begin
    w_wr_sel = '0;
    for (int i = 0; i < c_DEPTH; i++) begin
      if (write && (inaddress == ADDR_WIDTH'(i))) begin
        w_wr_sel[i] = 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < c_DEPTH; g++) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          r_regs[g]  <= '0;
          r_valid[g] <= 1'b0;
        end else if (w_wr_sel[g]) begin
          r_regs[g]  <= in;
          r_valid[g] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrcount <= 8'd0;
    end else if (write) begin
      r_wrcount <= r_wrcount + 8'd1;
    end
  end

`ifdef REG_BYPASS_EN
  // A reset cycle discards the write, so it must not be forwarded either.
  assign w_fwd1 = write && !reset && (out1address == inaddress);
  assign w_fwd2 = write && !reset && (out2address == inaddress);
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif

  assign regout1   = w_fwd1 ? in : r_regs[out1address];
  assign regout2   = w_fwd2 ? in : r_regs[out2address];
  assign out1valid = w_fwd1 | r_valid[out1address];
  assign out2valid = w_fwd2 | r_valid[out2address];
  assign wrcount   = r_wrcount;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_8x8.sv
// ============================================================================
// Module   : tb_reg_file_8x8
// Summary  : Directed self-checking bench for reg_file_8x8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_8x8;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic [2:0] inaddress;
  logic       write;
  logic [2:0] out1address;
  logic [2:0] out2address;
  logic [7:0] regout1;
  logic [7:0] regout2;
  logic       out1valid;
  logic       out2valid;
  logic [7:0] wrcount;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .inaddress   (inaddress),
    .write       (write),
    .out1address (out1address),
    .out2address (out2address),
    .regout1     (regout1),
    .regout2     (regout2),
    .out1valid   (out1valid),
    .out2valid   (out2valid),
    .wrcount     (wrcount)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    in        = d;
    inaddress = a;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_wrcount(input string name, input logic [7:0] exp);
    n_cmp++;
    if (wrcount !== exp) begin
      n_err++;
      $display("FAIL %s wrcount got=%0d exp=%0d", name, wrcount, exp);
    end
  endtask

  task automatic test_reset();
    wr(3'd1, 8'h5C);
    wr(3'd6, 8'hE3);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      out1address = 3'(i);
      out2address = 3'(7 - i);
      #1;
      n_cmp++;
      if (regout1 !== 8'h00 || regout2 !== 8'h00 || out1valid !== 1'b0 || out2valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_read a=%0d got rd1=%h rd2=%h v1=%b v2=%b exp 00/00/0/0",
                 i, regout1, regout2, out1valid, out2valid);
      end
    end
    chk_wrcount("reset", 8'd0);
  endtask

  task automatic test_write_read_all();
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      out1address = 3'(i);
      out2address = 3'(7 - i);
      #1;
      n_cmp++;
      if (regout1 !== 8'h10 + 8'(i) || regout2 !== 8'h17 - 8'(i) || out1valid !== 1'b1 || out2valid !== 1'b1) begin
        n_err++;
        $display("FAIL rw_all i=%0d got rd1=%h rd2=%h v1=%b v2=%b exp %h/%h/1/1",
                 i, regout1, regout2, out1valid, out2valid, 8'h10 + 8'(i), 8'h17 - 8'(i));
      end
    end
    chk_wrcount("rw_all", 8'd8);
  endtask

  task automatic test_partial_valid();
    do_reset();
    wr(3'd4, 8'hC7);
    for (int i = 0; i < 8; i++) begin
      out1address = 3'(i);
      out2address = 3'(i);
      #1;
      n_cmp++;
      if (regout1 !== ((i == 4) ? 8'hC7 : 8'h00) || out2valid !== (i == 4)) begin
        n_err++;
        $display("FAIL partial a=%0d got rd1=%h v2=%b exp %h/%b",
                 i, regout1, out2valid, (i == 4) ? 8'hC7 : 8'h00, (i == 4));
      end
    end
    chk_wrcount("partial", 8'd1);
  endtask

  task automatic test_priority();
    wr(3'd3, 8'h33);
    reset     = 1'b1;
    write     = 1'b1;
    in        = 8'hAA;
    inaddress = 3'd3;
    tick();
    reset = 1'b0;
    write = 1'b0;
    out1address = 3'd3;
    out2address = 3'd4;
    #1;
    n_cmp++;
    if (regout1 !== 8'h00 || out1valid !== 1'b0 || regout2 !== 8'h00 || out2valid !== 1'b0) begin
      n_err++;
      $display("FAIL priority got rd1=%h v1=%b rd2=%h v2=%b exp 00/0/00/0",
               regout1, out1valid, regout2, out2valid);
    end
    chk_wrcount("priority", 8'd0);
  endtask

  task automatic test_same_cycle();
    logic [7:0] exp_pre;
`ifdef REG_BYPASS_EN
    exp_pre = 8'h99;
`else
    exp_pre = 8'h22;
`endif
    do_reset();
    wr(3'd5, 8'h22);
    in          = 8'h99;
    inaddress   = 3'd5;
    write       = 1'b1;
    out1address = 3'd5;
    out2address = 3'd6;
    #1;
    n_cmp++;
    if (regout1 !== exp_pre || out1valid !== 1'b1) begin
      n_err++;
      $display("FAIL same_pre got rd1=%h v1=%b exp %h/1", regout1, out1valid, exp_pre);
    end
    n_cmp++;
    if (regout2 !== 8'h00 || out2valid !== 1'b0) begin
      n_err++;
      $display("FAIL same_other got rd2=%h v2=%b exp 00/0", regout2, out2valid);
    end
    tick();
    write = 1'b0;
    #1;
    n_cmp++;
    if (regout1 !== 8'h99) begin
      n_err++;
      $display("FAIL same_post got rd1=%h exp 99", regout1);
    end
    chk_wrcount("same_cycle", 8'd2);
  endtask

  task automatic test_hold();
    wr(3'd2, 8'h5A);
    in        = 8'hFF;
    inaddress = 3'd2;
    write     = 1'b0;
    repeat (4) tick();
    out1address = 3'd2;
    #1;
    n_cmp++;
    if (regout1 !== 8'h5A || out1valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold got rd1=%h v1=%b exp 5a/1", regout1, out1valid);
    end
    chk_wrcount("hold", 8'd3);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8];
    do_reset();
    exp = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h80, 8'h7E, 8'h00, 8'hD2};
    write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inaddress = 3'(7 - i);
      in        = exp[7 - i];
      tick();
    end
    wr(3'd0, 8'h4B);
    exp[0] = 8'h4B;
    for (int i = 0; i < 8; i++) begin
      out1address = 3'(i);
      out2address = 3'(i);
      #1;
      n_cmp++;
      if (regout1 !== exp[i] || regout2 !== exp[i] || out1valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b a=%0d got rd1=%h rd2=%h v1=%b exp %h/1",
                 i, regout1, regout2, out1valid, exp[i]);
      end
    end
    chk_wrcount("b2b", 8'd9);
  endtask

  task automatic test_wrap();
    do_reset();
    write = 1'b1;
    for (int i = 0; i < 255; i++) begin
      inaddress = 3'(i);
      in        = 8'(i);
      tick();
    end
    chk_wrcount("wrap_255", 8'd255);
    tick();
    chk_wrcount("wrap_256", 8'd0);
    tick();
    write = 1'b0;
    chk_wrcount("wrap_257", 8'd1);
  endtask

  initial begin
    reset       = 1'b1;
    write       = 1'b0;
    in          = 8'h00;
    inaddress   = 3'd0;
    out1address = 3'd0;
    out2address = 3'd0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_write_read_all();
    test_partial_valid();
    test_priority();
    test_same_cycle();
    test_hold();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
